mdr_seq_ctrl: RTL and testbench
===============================

// Module: mdr_seq_ctrl
// PURPOSE
//  Control FSM for the sequential shift-add multiplier datapath.
//  - Takes the debounced one-cycle start pulse and drives load, add, shift and clear strobes for DW iterations.
//  - Reports busy/done/valid to the top level and the display logic.
//  - Holds no operand data; it only sequences the datapath.
// PARAMETERS
//  DW     8              operand width, i.e. number of add/shift iterations (DW >= 2)
//  CNT_W  $clog2(DW)     localparam: width of the iteration counter
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-low
//  start_i   in   1      one-cycle start pulse (debouncer one_shot)
//  op_lsb_i  in   1      current LSB of the datapath multiplier register
//  load_o    out  1      load operands into datapath registers
//  clear_o   out  1      clear product accumulator
//  add_o     out  1      add multiplicand to accumulator this cycle
//  sub_o     out  1      subtract multiplicand this cycle (signed build only; else 0)
//  shift_o   out  1      shift accumulator/multiplier this cycle
//  busy_o    out  1      high in LOAD and CALC
//  done_o    out  1      one-cycle pulse, product complete
//  valid_o   out  1      level: product register holds a valid result
//  iter_o    out  CNT_W  current iteration index
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, every output 0 (valid_o included). Reset asserted mid-operation aborts immediately with no done_o.
//  - States (package enum): IDLE, LOAD, CALC, DONE. All strobes are Moore outputs except add_o/sub_o, which are qualified by op_lsb_i.
//  - IDLE: start_i=1 -> LOAD; otherwise stay. valid_o keeps its value.
//  - LOAD (1 cycle): load_o=1, clear_o=1, busy_o=1, valid_o<=0, counter<=0 -> CALC.
//  - CALC (DW cycles):
//    - shift_o=1, busy_o=1, add_o=op_lsb_i.
//    - Counter increments each cycle.
//    - When the counter equals DW-1, the iteration's strobes still fire, then -> DONE.
//  - DONE (1 cycle): done_o=1, valid_o<=1 -> IDLE.
//  - Latency: start_i sampled at edge k -> LOAD in cycle k+1, CALC k+2..k+DW+1, done_o in cycle k+DW+2.
//  - start_i is ignored in LOAD, CALC and DONE; there is no queuing.
//  - A start in IDLE while valid_o=1 re-runs the sequence; valid_o drops in LOAD.
//  - The counter never wraps; it resets to 0 in LOAD. iter_o = counter.
//  - add_o and sub_o are never both 1. load_o, clear_o and shift_o are never high in the same cycle except load_o with clear_o.
// CONFIGURATION
//  - MDR_SIGNED_EN defined: two's-complement mode.
//    - On the last CALC iteration (counter==DW-1) with op_lsb_i=1, sub_o=1 and add_o=0.
//    - The datapath shift is arithmetic.
//  - MDR_SIGNED_EN undefined: unsigned mode; sub_o tied 0, add_o=op_lsb_i on every iteration.
// STRUCTURE
//  - Package mdr_ctrl_pkg: mdr_ctrl_state_e enum, TRUE_CTRL/FALSE_CTRL constants, DW default constant.
//  - Sub-module mdr_iter_counter: CNT_W-bit counter with clr/en inputs and a last_o flag (count==DW-1), asynchronous active-low reset.
//  - The FSM is split into next-state, state-register and output blocks.
// TESTING (DW=8)
//  1. Assert rst low mid-run, release -> all outputs 0, state IDLE, iter_o=0.
//  2. Start pulse, op_lsb_i sequence 1,1,0,1,0,0,0,0 -> add_o pattern matches.
//     - shift_o high for exactly 8 cycles.
//     - done_o in cycle 10 after start; valid_o=1 afterward.
//  3. Start pulses during CALC iteration 3 and in the DONE cycle -> ignored; single done_o, no extra LOAD.
//  4. Second start while valid_o=1 -> valid_o=0 in LOAD, back to 1 after done_o.
//  5. rst low at CALC iteration 5 -> no done_o, valid_o=0, next start runs full 8 iterations.
//  6. op_lsb_i=1 on all iterations:
//     - MDR_SIGNED_EN: iter 7 gives sub_o=1, add_o=0.
//     - Without the macro: add_o=1 on all 8 iterations, sub_o never 1.

Source files
------------

// File: rtl/mdr_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package mdr_ctrl_pkg;

    localparam int   DW_DEFAULT = 8;
    localparam logic TRUE_CTRL  = 1'b1;
    localparam logic FALSE_CTRL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } mdr_ctrl_state_e;

endpackage

// File: rtl/mdr_iter_counter.sv
// Iteration counter for the multiplier sequencer; saturates at DW-1 so it never wraps.
module mdr_iter_counter
    import mdr_ctrl_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    localparam int CNT_W = $clog2(DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last_o  = (count_q == CNT_W'(DW - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !last_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mdr_seq_ctrl.sv
// Sequencing FSM for the shift-add multiplier datapath.
// Define MDR_SIGNED_EN for two's-complement mode (subtract on the final iteration).
module mdr_seq_ctrl
    import mdr_ctrl_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    localparam int CNT_W = $clog2(DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_lsb_i,
    output logic             load_o,
    output logic             clear_o,
    output logic             add_o,
    output logic             sub_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] iter_o
);

    mdr_ctrl_state_e state_q;
    mdr_ctrl_state_e state_d;
    logic            valid_q;
    logic            valid_d;
    logic            cnt_last;

    mdr_iter_counter #(.DW(DW)) u_iter_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == LOAD),
        .en_i    (state_q == CALC),
        .count_o (iter_o),
        .last_o  (cnt_last)
    );

    // valid clears on the IDLE->LOAD transition so it already reads 0 during LOAD
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    valid_d = FALSE_CTRL;
                end
            end
            LOAD: begin
                state_d = CALC;
                valid_d = FALSE_CTRL;
            end
            CALC: begin
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = TRUE_CTRL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= FALSE_CTRL;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        load_o  = FALSE_CTRL;
        clear_o = FALSE_CTRL;
        add_o   = FALSE_CTRL;
        sub_o   = FALSE_CTRL;
        shift_o = FALSE_CTRL;
        busy_o  = FALSE_CTRL;
        done_o  = FALSE_CTRL;
        case (state_q)
            LOAD: begin
                load_o  = TRUE_CTRL;
                clear_o = TRUE_CTRL;
                busy_o  = TRUE_CTRL;
            end
            CALC: begin
                shift_o = TRUE_CTRL;
                busy_o  = TRUE_CTRL;
`ifdef MDR_SIGNED_EN
                // sign bit of the multiplier carries negative weight
                add_o   = op_lsb_i && !cnt_last;
                sub_o   = op_lsb_i && cnt_last;
`else
                add_o   = op_lsb_i;
`endif
            end
            DONE: begin
                done_o  = TRUE_CTRL;
            end
            default: begin
            end
        endcase
    end

    assign valid_o = valid_q;

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Directed self-checking bench for mdr_seq_ctrl (DW=8).
module tb_mdr_seq_ctrl;

    localparam int DW    = 8;
    localparam int CNT_W = $clog2(DW);
`ifdef MDR_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             start_i  = 1'b0;
    logic             op_lsb_i = 1'b0;
    logic             load_o, clear_o, add_o, sub_o, shift_o, busy_o, done_o, valid_o;
    logic [CNT_W-1:0] iter_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdr_seq_ctrl #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_lsb_i (op_lsb_i),
        .load_o   (load_o),
        .clear_o  (clear_o),
        .add_o    (add_o),
        .sub_o    (sub_o),
        .shift_o  (shift_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .valid_o  (valid_o),
        .iter_o   (iter_o)
    );

    // output vector order: load clear add sub shift busy done valid
    function automatic logic [7:0] outs();
        return {load_o, clear_o, add_o, sub_o, shift_o, busy_o, done_o, valid_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled mid-cycle, well away from the rising edge
    task automatic step(input logic s, input logic l);
        @(posedge clk);
        #2;
        start_i  = s;
        op_lsb_i = l;
        #2;
    endtask

    task automatic run_op(input string tag, input logic [7:0] pat, input logic valid_before,
                          input int start_iter, input logic start_done, input int abort_iter);
        int          shifts;
        logic        add_e;
        logic        sub_e;
        shifts = 0;
        step(1'b1, 1'b0);
        check({tag, " idle"}, 32'(outs()), {24'd0, 7'd0, valid_before});
        step(1'b0, 1'b0);
        check({tag, " load"}, 32'(outs()), 32'b1100_0100);
        for (int i = 0; i < DW; i++) begin
            step(i == start_iter, pat[i]);
            add_e = pat[i] && !(SIGNED_MODE && i == DW - 1);
            sub_e = pat[i] && SIGNED_MODE && i == DW - 1;
            check({tag, " calc"}, 32'(outs()), {24'd0, 2'b00, add_e, sub_e, 4'b1100});
            check({tag, " iter"}, 32'(iter_o), i);
            shifts += int'(shift_o);
            if (i == abort_iter) begin
                #1 rst = 1'b0;
                #1;
                check({tag, " abort outs"}, 32'(outs()), 32'd0);
                check({tag, " abort iter"}, 32'(iter_o), 32'd0);
                for (int j = 0; j < 3; j++) begin
                    step(1'b0, 1'b0);
                    check({tag, " held reset"}, 32'(outs()), 32'd0);
                end
                #1 rst = 1'b1;
                return;
            end
        end
        check({tag, " shift count"}, shifts, DW);
        step(start_done, 1'b0);
        check({tag, " done"}, 32'(outs()), 32'b0000_0010);
        check({tag, " done iter"}, 32'(iter_o), DW - 1);
        step(1'b0, 1'b0);
        check({tag, " post1"}, 32'(outs()), 32'b0000_0001);
        step(1'b0, 1'b0);
        check({tag, " post2"}, 32'(outs()), 32'b0000_0001);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset outs", 32'(outs()), 32'd0);
        check("reset iter", 32'(iter_o), 32'd0);
        #1 rst = 1'b1;

        // reset mid-run early in CALC
        run_op("t1", 8'b1111_0000, 1'b0, -1, 1'b0, 2);
        // 1,1,0,1,0,0,0,0 on iterations 0..7
        run_op("t2", 8'b0000_1011, 1'b0, -1, 1'b0, -1);
        // stray starts in CALC iteration 3 and in DONE are ignored
        run_op("t3", 8'b1010_0110, 1'b1, 3, 1'b1, -1);
        // rerun while valid is already high
        run_op("t4", 8'b0101_1010, 1'b1, -1, 1'b0, -1);
        // abort at iteration 5, then a full clean run
        run_op("t5a", 8'b0011_1100, 1'b1, -1, 1'b0, 5);
        run_op("t5b", 8'b1100_0011, 1'b0, -1, 1'b0, -1);
        // multiplier LSB high on every iteration
        run_op("t6", 8'b1111_1111, 1'b1, -1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
